// File: rtl/clock_counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : clock_counter_scheduler
// Description : Round-robin latch/capture controller for a bank of
//               clock_counter instances; streams one result per measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_counter_scheduler #(
    parameter int NUM_COUNTERS        = 4,
    parameter int CLOCK_COUNTER_WIDTH = 64,
    parameter int INTERVAL_CYCLES     = 1000000,
    parameter int TIMEOUT_CYCLES      = 4096,
    localparam int c_IDX_W            = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_enable,
    output logic [NUM_COUNTERS-1:0]                     o_latch_counters,
    input  logic [NUM_COUNTERS-1:0]                     i_counter_valid,
    input  logic [NUM_COUNTERS*CLOCK_COUNTER_WIDTH-1:0] i_clk_local_counter,
    input  logic [NUM_COUNTERS*CLOCK_COUNTER_WIDTH-1:0] i_clk_extern_counter,
    output logic                                        o_result_valid,
    input  logic                                        i_result_ready,
    output logic [c_IDX_W-1:0]                          o_result_index,
    output logic [CLOCK_COUNTER_WIDTH-1:0]              o_result_local_count,
    output logic [CLOCK_COUNTER_WIDTH-1:0]              o_result_extern_count,
    output logic                                        o_result_timeout
);

    localparam int c_W   = CLOCK_COUNTER_WIDTH;
    localparam int c_ICW = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;
    localparam int c_TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_ICW-1:0]   c_INTERVAL_LAST = c_ICW'(INTERVAL_CYCLES - 1);
    localparam logic [c_TCW-1:0]   c_TIMEOUT_LAST  = c_TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST      = c_IDX_W'(NUM_COUNTERS - 1);

    localparam logic [2:0] c_IDLE          = 3'd0;
    localparam logic [2:0] c_WAIT_INTERVAL = 3'd1;
    localparam logic [2:0] c_CHECK_READY   = 3'd2;
    localparam logic [2:0] c_LATCH         = 3'd3;
    localparam logic [2:0] c_SETTLE        = 3'd4;
    localparam logic [2:0] c_WAIT_VALID    = 3'd5;
    localparam logic [2:0] c_OUTPUT        = 3'd6;
    localparam logic [2:0] c_TIMEOUT_OUT   = 3'd7;

    logic [2:0]              r_state;
    logic [c_IDX_W-1:0]      r_idx;
    logic [NUM_COUNTERS-1:0] r_primed;
    logic [c_ICW-1:0]        r_interval_cnt;
    logic [c_TCW-1:0]        r_timeout_cnt;

    logic                    w_sel_valid;
    logic                    w_sel_primed;
    logic [c_W-1:0]          w_sel_local;
    logic [c_W-1:0]          w_sel_extern;
    logic [NUM_COUNTERS-1:0] w_latch_onehot;
    logic [c_IDX_W-1:0]      w_idx_next;
    logic                    w_timeout_hit;

    // Per-index selection of the counter currently being measured
    always_comb begin
        w_sel_valid    = 1'b0;
        w_sel_primed   = 1'b0;
        w_sel_local    = '0;
        w_sel_extern   = '0;
        w_latch_onehot = '0;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_sel_valid       = i_counter_valid[k];
                w_sel_primed      = r_primed[k];
                w_sel_local       = i_clk_local_counter[k*c_W +: c_W];
                w_sel_extern      = i_clk_extern_counter[k*c_W +: c_W];
                w_latch_onehot[k] = 1'b1;
            end
        end
        w_idx_next    = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        w_timeout_hit = (r_timeout_cnt == c_TIMEOUT_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state               <= c_IDLE;
            r_idx                 <= '0;
            r_primed              <= '0;
            r_interval_cnt        <= '0;
            r_timeout_cnt         <= '0;
            o_latch_counters      <= '0;
            o_result_valid        <= 1'b0;
            o_result_index        <= '0;
            o_result_local_count  <= '0;
            o_result_extern_count <= '0;
            o_result_timeout      <= 1'b0;
        end else begin
            o_latch_counters <= '0;
            case (r_state)
                c_IDLE: begin
                    if (i_enable) begin
                        r_state        <= c_WAIT_INTERVAL;
                        r_interval_cnt <= '0;
                    end
                end
                c_WAIT_INTERVAL: begin
                    if (!i_enable) begin
                        r_state  <= c_IDLE;
                        r_idx    <= '0;
                        r_primed <= '0;
                    end else if (r_interval_cnt == c_INTERVAL_LAST) begin
                        r_state       <= c_CHECK_READY;
                        r_timeout_cnt <= '0;
                    end else begin
                        r_interval_cnt <= r_interval_cnt + c_ICW'(1);
                    end
                end
                c_CHECK_READY: begin
                    if (w_sel_valid) begin
                        r_state          <= c_LATCH;
                        o_latch_counters <= w_latch_onehot;
                    end else if (w_timeout_hit) begin
                        r_state               <= c_TIMEOUT_OUT;
                        o_result_valid        <= 1'b1;
                        o_result_index        <= r_idx;
                        o_result_local_count  <= '0;
                        o_result_extern_count <= '0;
                        o_result_timeout      <= 1'b1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + c_TCW'(1);
                    end
                end
                c_LATCH: begin
                    r_state <= c_SETTLE;
                end
                // Counter drops valid on the latch edge, so skip one cycle
                c_SETTLE: begin
                    r_state       <= c_WAIT_VALID;
                    r_timeout_cnt <= '0;
                end
                c_WAIT_VALID: begin
                    if (w_sel_valid) begin
                        if (w_sel_primed) begin
                            r_state               <= c_OUTPUT;
                            o_result_valid        <= 1'b1;
                            o_result_index        <= r_idx;
                            o_result_local_count  <= w_sel_local;
                            o_result_extern_count <= w_sel_extern;
                            o_result_timeout      <= 1'b0;
                        end else begin
                            // First window has an undefined start: discard it
                            r_primed[r_idx] <= 1'b1;
                            r_idx           <= w_idx_next;
                            r_state         <= c_WAIT_INTERVAL;
                            r_interval_cnt  <= '0;
                        end
                    end else if (w_timeout_hit) begin
                        r_state               <= c_TIMEOUT_OUT;
                        r_primed[r_idx]       <= 1'b0;
                        o_result_valid        <= 1'b1;
                        o_result_index        <= r_idx;
                        o_result_local_count  <= '0;
                        o_result_extern_count <= '0;
                        o_result_timeout      <= 1'b1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + c_TCW'(1);
                    end
                end
                c_OUTPUT, c_TIMEOUT_OUT: begin
                    if (i_result_ready) begin
                        o_result_valid <= 1'b0;
                        r_idx          <= w_idx_next;
                        r_state        <= c_WAIT_INTERVAL;
                        r_interval_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_counter_scheduler
// Description : Self-checking bench: emulated counters, measurement-level
//               timing/result model, directed steps plus random measurements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_counter_scheduler;

    localparam int N        = 2;
    localparam int W        = 32;
    localparam int INTERVAL = 100;
    localparam int TIMEOUT  = 16;
    localparam int IW       = 1;

    localparam int M_NORMAL = 0;
    localparam int M_NORET  = 1;
    localparam int M_DEAD   = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           ready;
    logic [N-1:0]   latch;
    logic [N-1:0]   cvalid;
    logic [N*W-1:0] loc_bus;
    logic [N*W-1:0] ext_bus;
    logic           rvalid;
    logic [IW-1:0]  ridx;
    logic [W-1:0]   rloc;
    logic [W-1:0]   rext;
    logic           rtmo;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0       = 0;

    int       m_idx;
    bit       m_primed [N];
    int       pend     [N];
    int       ret_d    [N];
    bit       noret    [N];
    bit       dead     [N];
    logic [W-1:0] exp_loc [N];
    logic [W-1:0] exp_ext [N];

    always #5 clk = ~clk;

    clock_counter_scheduler #(
        .NUM_COUNTERS        (N),
        .CLOCK_COUNTER_WIDTH (W),
        .INTERVAL_CYCLES     (INTERVAL),
        .TIMEOUT_CYCLES      (TIMEOUT)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_enable              (enable),
        .o_latch_counters      (latch),
        .i_counter_valid       (cvalid),
        .i_clk_local_counter   (loc_bus),
        .i_clk_extern_counter  (ext_bus),
        .o_result_valid        (rvalid),
        .i_result_ready        (ready),
        .o_result_index        (ridx),
        .o_result_local_count  (rloc),
        .o_result_extern_count (rext),
        .o_result_timeout      (rtmo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic new_counts(input int k);
        exp_loc[k] = W'($urandom);
        exp_ext[k] = W'($urandom);
        loc_bus[k*W +: W] = exp_loc[k];
        ext_bus[k*W +: W] = exp_ext[k];
    endtask

    // One clock; emulated counters drop valid on a latch and re-arm later
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (pend[k] > 0) begin
                pend[k]--;
                if (pend[k] == 0) begin
                    cvalid[k] = 1'b1;
                    new_counts(k);
                end
            end
            if (latch[k]) begin
                cvalid[k] = 1'b0;
                loc_bus[k*W +: W] = W'($urandom);
                ext_bus[k*W +: W] = W'($urandom);
                if (!noret[k]) pend[k] = ret_d[k] + 2;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_latch", 64'(latch), 64'(0));
            chk("idle_rvalid", 64'(rvalid), 64'(0));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_latch", 64'(latch), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_index", 64'(ridx), 64'(0));
        chk("rst_local", 64'(rloc), 64'(0));
        chk("rst_extern", 64'(rext), 64'(0));
        chk("rst_timeout", 64'(rtmo), 64'(0));
        enable = 1'b0;
        ready  = 1'b0;
        for (int k = 0; k < N; k++) begin
            pend[k]     = 0;
            noret[k]    = 1'b0;
            dead[k]     = 1'b0;
            cvalid[k]   = 1'b1;
            m_primed[k] = 1'b0;
            new_counts(k);
        end
        m_idx = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        enable = 1'b1;
        c0 = cyc + 1;
    endtask

    // One measurement of counter m_idx; called in the cycle before its interval.
    // abort_at >= 0 stops the run abort_at cycles after the latch pulse.
    task automatic measure(input int mode, input int d, input int stall, input int abort_at);
        int k, L, R, c0_next;
        bit has_res, tmo, rv_exp;
        logic [N-1:0] el;
        k = m_idx;
        L = -1;
        tmo = 1'b1;
        has_res = 1'b1;
        if (mode == M_DEAD) begin
            R = c0 + INTERVAL + TIMEOUT;
        end else if (mode == M_NORET) begin
            L = c0 + INTERVAL + 1;
            R = L + 2 + TIMEOUT;
        end else begin
            L = c0 + INTERVAL + 1;
            R = L + 3 + d;
            tmo = 1'b0;
            has_res = m_primed[k];
        end
        c0_next = has_res ? R + stall + 1 : R;
        ret_d[k] = d;
        noret[k] = (mode == M_NORET);
        dead[k]  = (mode == M_DEAD);
        if (dead[k]) cvalid[k] = 1'b0;
        while (cyc < c0_next - 1) begin
            tick();
            el = '0;
            if (cyc == L) el[k] = 1'b1;
            chk("latch", 64'(latch), 64'(el));
            rv_exp = has_res && (cyc >= R) && (cyc <= R + stall);
            chk("rvalid", 64'(rvalid), 64'(rv_exp));
            if (rv_exp) begin
                chk("index", 64'(ridx), 64'(k));
                chk("timeout", 64'(rtmo), 64'(tmo));
                chk("local", 64'(rloc), tmo ? 64'(0) : 64'(exp_loc[k]));
                chk("extern", 64'(rext), tmo ? 64'(0) : 64'(exp_ext[k]));
            end
            ready  = rv_exp ? (cyc == R + stall) : 1'($urandom_range(0, 1));
            enable = (cyc >= c0 + INTERVAL) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_at >= 0 && L >= 0 && cyc == L + abort_at) return;
        end
        if (mode == M_NORMAL && !m_primed[k]) m_primed[k] = 1'b1;
        else if (mode == M_NORET) m_primed[k] = 1'b0;
        if (mode != M_NORMAL) begin
            cvalid[k] = 1'b1;
            new_counts(k);
        end
        noret[k] = 1'b0;
        dead[k]  = 1'b0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
        c0 = c0_next;
    endtask

    initial begin
        int r, mode;
        rst_n  = 1'b0;
        enable = 1'b0;
        ready  = 1'b0;
        cvalid = '1;
        for (int k = 0; k < N; k++) begin
            pend[k] = 0;
            ret_d[k] = 0;
            noret[k] = 1'b0;
            dead[k] = 1'b0;
            new_counts(k);
        end
        tick();
        tick();
        do_reset();
        idle_cycles(10);

        start_run();
        measure(M_NORMAL, 0, 0, -1);
        measure(M_NORMAL, 2, 0, -1);
        measure(M_NORMAL, 3, 1, -1);
        measure(M_NORMAL, 15, 0, -1);
        measure(M_NORMAL, 0, 0, -1);
        measure(M_DEAD, 0, 2, -1);
        measure(M_NORMAL, 5, 0, -1);
        measure(M_NORMAL, 1, 0, -1);
        measure(M_NORET, 0, 0, -1);
        measure(M_NORMAL, 4, 0, -1);
        measure(M_NORMAL, 2, 0, -1);
        measure(M_NORMAL, 0, 50, -1);
        measure(M_NORMAL, 6, 0, -1);

        // Drop enable mid-interval while idx is 1; resume restarts at counter 0
        enable = 1'b1;
        idle_cycles(37);
        enable = 1'b0;
        idle_cycles(12);
        m_idx = 0;
        for (int k = 0; k < N; k++) m_primed[k] = 1'b0;
        start_run();
        measure(M_NORMAL, 1, 0, -1);
        measure(M_NORMAL, 0, 0, -1);
        measure(M_NORMAL, 3, 0, -1);

        measure(M_NORET, 0, 0, 5);
        do_reset();
        idle_cycles(20);
        start_run();
        measure(M_NORMAL, 0, 0, -1);
        measure(M_NORMAL, 0, 0, 0);
        do_reset();
        idle_cycles(5);
        start_run();

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            mode = (r < 7) ? M_NORMAL : ((r < 8) ? M_NORET : M_DEAD);
            measure(mode, $urandom_range(0, 15), $urandom_range(0, 4), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
